// File: rtl/quad_stream_ctrl.sv
// Frame sequencer for the fixed-point quad datapath (dp_a,dp_b -> dp_c).
// Latency: operand handshake at cycle t -> out_valid/out_c at t+LATENCY+2.
// Backpressure: in_ready is driven from state/counters only; no output backpressure (sink always accepts).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, frame_len, cfg_frac_* frame request and configuration, sampled only in IDLE
//   in_valid, in_a, in_b, in_ready  operand-pair handshake
//   dp_a, dp_b, dp_frac_*, dp_c registered operands / latched config to, and result from, the datapath
//   out_valid, out_c, out_last  registered results, one cycle per sample
//   busy, done                  RUN/DRAIN indicator, one-cycle frame-completion pulse
module quad_stream_ctrl #(
  parameter int A_W     = 14,
  parameter int B_W     = 14,
  parameter int C_W     = 29,
  parameter int FRAC_W  = 8,
  parameter int LATENCY = 3,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [FRAC_W-1:0] cfg_frac_a,
  input  logic [FRAC_W-1:0] cfg_frac_b,
  input  logic [FRAC_W-1:0] cfg_frac_c,
  input  logic              in_valid,
  input  logic [A_W-1:0]    in_a,
  input  logic [B_W-1:0]    in_b,
  output logic              in_ready,
  output logic [A_W-1:0]    dp_a,
  output logic [B_W-1:0]    dp_b,
  output logic [FRAC_W-1:0] dp_frac_a,
  output logic [FRAC_W-1:0] dp_frac_b,
  output logic [FRAC_W-1:0] dp_frac_c,
  input  logic [C_W-1:0]    dp_c,
  output logic              out_valid,
  output logic [C_W-1:0]    out_c,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] retired;
  // Bit k is set when the sample now at datapath stage k was a real transfer.
  logic [LATENCY:0] vpipe;
  logic             xfer;
  logic             tap;

  assign in_ready = (state == S_RUN) && (issued < len_q);
  assign xfer     = in_valid && in_ready;
  // Depth LATENCY lines up with dp_c for the operands registered LATENCY cycles earlier.
  assign tap      = vpipe[LATENCY];
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (frame_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issued == len_q) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (retired == len_q) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      issued    <= '0;
      retired   <= '0;
      vpipe     <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_frac_a <= '0;
      dp_frac_b <= '0;
      dp_frac_c <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_last  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        len_q     <= frame_len;
        dp_frac_a <= cfg_frac_a;
        dp_frac_b <= cfg_frac_b;
        dp_frac_c <= cfg_frac_c;
        issued    <= '0;
        retired   <= '0;
      end

      // Transfers only happen in RUN, so this never collides with the clear above.
      if (xfer) begin
        dp_a   <= in_a;
        dp_b   <= in_b;
        issued <= issued + LEN_W'(1);
      end

      vpipe <= {vpipe[LATENCY-1:0], xfer};

      out_valid <= tap;
      // Compared against the count before this sample is retired.
      out_last  <= tap && (retired == len_q - LEN_W'(1));
      if (tap) begin
        out_c   <= dp_c;
        retired <= retired + LEN_W'(1);
      end
    end
  end

endmodule
